// File: rtl/fir_coef_bank_ctrl.sv
// Double-buffered coefficient bank controller for the 2-sample parallel FIR.
// A TAPS-long coefficient set is streamed into the shadow bank over a
// valid/ready handshake. The new set becomes active only on a block-boundary
// swap strobe, so the filter never sees a half-loaded set.
module fir_coef_bank_ctrl #(
    parameter int TAPS       = 100,
    parameter int COEF_WIDTH = 16,
    parameter int CNT_WIDTH  = $clog2(TAPS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_abort,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [COEF_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  swap_en,
    output logic [COEF_WIDTH-1:0] coef [0:TAPS-1],
    output logic                  bank_sel,
    output logic [CNT_WIDTH-1:0]  load_cnt,
    output logic                  pending,
    output logic                  swap_done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t                state_q;
    logic                  bank_sel_q;
    logic                  s_ready_q;
    logic                  pending_q;
    logic                  swap_done_q;
    logic                  err_q;
    logic [CNT_WIDTH-1:0]  load_cnt_q;
    logic [COEF_WIDTH-1:0] bank0_q [0:TAPS-1];
    logic [COEF_WIDTH-1:0] bank1_q [0:TAPS-1];

    // A beat is written only when it is handshaken and not cancelled by abort.
    logic beat_wr;
    logic last_idx;

    assign beat_wr  = (state_q == LOAD) && s_valid && !load_abort;
    assign last_idx = (load_cnt_q == CNT_WIDTH'(TAPS - 1));

    // Control FSM: load sequencing, length checking, and the atomic bank swap.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bank_sel_q  <= 1'b0;
            s_ready_q   <= 1'b0;
            pending_q   <= 1'b0;
            swap_done_q <= 1'b0;
            err_q       <= 1'b0;
            load_cnt_q  <= '0;
        end else begin
            swap_done_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_q    <= LOAD;
                        s_ready_q  <= 1'b1;
                        load_cnt_q <= '0;
                    end
                end
                LOAD: begin
                    if (load_abort) begin
                        state_q   <= IDLE;
                        s_ready_q <= 1'b0;
                    end else if (s_valid) begin
                        load_cnt_q <= load_cnt_q + CNT_WIDTH'(1);
                        if (last_idx && s_last) begin
                            state_q   <= PENDING;
                            pending_q <= 1'b1;
                            s_ready_q <= 1'b0;
                        end else if (last_idx || s_last) begin
                            // Set length disagrees with s_last: drop the set.
                            state_q   <= IDLE;
                            err_q     <= 1'b1;
                            s_ready_q <= 1'b0;
                        end
                    end
                end
                PENDING: begin
                    // The swap outranks a concurrent load_start.
                    if (swap_en) begin
                        state_q     <= IDLE;
                        bank_sel_q  <= ~bank_sel_q;
                        pending_q   <= 1'b0;
                        swap_done_q <= 1'b1;
                    end else if (load_start) begin
                        state_q    <= LOAD;
                        pending_q  <= 1'b0;
                        s_ready_q  <= 1'b1;
                        load_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    s_ready_q <= 1'b0;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    // Coefficient storage: accepted beats go to the bank not currently active.
    // NOTE: the banks are reset on purpose, because the active set must read
    // as all-zero immediately after reset rather than as stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                bank0_q[i] <= '0;
                bank1_q[i] <= '0;
            end
        end else if (beat_wr) begin
            for (int i = 0; i < TAPS; i++) begin
                if (load_cnt_q == CNT_WIDTH'(i)) begin
                    if (bank_sel_q) begin
                        bank0_q[i] <= s_data;
                    end else begin
                        bank1_q[i] <= s_data;
                    end
                end
            end
        end
    end

    // Active coefficient array: a plain mux of two registered banks, so it
    // changes only when bank_sel_q flips at a clock edge.
    // NOTE: every element is assigned on every pass, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            coef[i] = bank_sel_q ? bank1_q[i] : bank0_q[i];
        end
    end

    assign s_ready   = s_ready_q;
    assign bank_sel  = bank_sel_q;
    assign load_cnt  = load_cnt_q;
    assign pending   = pending_q;
    assign swap_done = swap_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// Directed bench for fir_coef_bank_ctrl with a 4-tap bank. Each step applies
// inputs, advances one clock, and compares outputs 1 ns after the rising edge
// against hand-computed values.
module tb_fir_coef_bank_ctrl;

    localparam int TAPS       = 4;
    localparam int COEF_WIDTH = 16;
    localparam int CNT_WIDTH  = $clog2(TAPS + 1);

    logic                  clk;
    logic                  rst_n;
    logic                  load_start;
    logic                  load_abort;
    logic                  s_valid;
    logic                  s_ready;
    logic [COEF_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  swap_en;
    logic [COEF_WIDTH-1:0] coef [0:TAPS-1];
    logic                  bank_sel;
    logic [CNT_WIDTH-1:0]  load_cnt;
    logic                  pending;
    logic                  swap_done;
    logic                  err;

    int total = 0;
    int bad   = 0;

    fir_coef_bank_ctrl #(
        .TAPS       (TAPS),
        .COEF_WIDTH (COEF_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_abort (load_abort),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .swap_en    (swap_en),
        .coef       (coef),
        .bank_sel   (bank_sel),
        .load_cnt   (load_cnt),
        .pending    (pending),
        .swap_done  (swap_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] coef_all();
        return {coef[0], coef[1], coef[2], coef[3]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 16'h0000;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic do_swap();
        swap_en = 1'b1;
        step();
        swap_en = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b1;
        load_start = 1'b0;
        load_abort = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        swap_en    = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        // Reset state
        check("rst_coef",     coef_all(), 64'h0);
        check("rst_bank_sel", bank_sel,   0);
        check("rst_s_ready",  s_ready,    0);
        check("rst_load_cnt", load_cnt,   0);
        check("rst_pending",  pending,    0);
        check("rst_swap_done", swap_done, 0);
        check("rst_err",      err,        0);
        #9 rst_n = 1'b1;
        step();

        // Basic load with gapped valid, then swap
        start_load();
        check("ld1_s_ready", s_ready, 1);
        check("ld1_cnt0",    load_cnt, 0);
        beat(16'h0100, 1'b0);
        check("ld1_cnt1", load_cnt, 1);
        s_data = 16'hDEAD;
        step();
        check("ld1_gap_cnt", load_cnt, 1);
        beat(16'h0200, 1'b0);
        check("ld1_cnt2", load_cnt, 2);
        step();
        beat(16'h0300, 1'b0);
        check("ld1_cnt3", load_cnt, 3);
        step();
        beat(16'h0400, 1'b1);
        check("ld1_cnt4",     load_cnt, 4);
        check("ld1_pending",  pending,  1);
        check("ld1_ready_lo", s_ready,  0);
        check("ld1_coef_old", coef_all(), 64'h0);
        check("ld1_bank_sel_old", bank_sel, 0);
        // Beat offered while pending must be ignored
        beat(16'hBEEF, 1'b0);
        check("pend_beat_cnt", load_cnt, 4);
        check("pend_still",    pending,  1);
        do_swap();
        check("sw1_coef",      coef_all(), 64'h0100_0200_0300_0400);
        check("sw1_bank_sel",  bank_sel,  1);
        check("sw1_swap_done", swap_done, 1);
        check("sw1_pending",   pending,   0);
        step();
        check("sw1_done_drop", swap_done, 0);
        check("sw1_coef_hold", coef_all(), 64'h0100_0200_0300_0400);
        // Beat offered in IDLE must be ignored
        beat(16'h7777, 1'b0);
        check("idle_ready",   s_ready,  0);
        check("idle_cnt_hold", load_cnt, 4);

        // Short set: s_last on beat 2 of 4
        start_load();
        beat(16'h1111, 1'b0);
        beat(16'h2222, 1'b1);
        check("short_err",     err,      1);
        check("short_pending", pending,  0);
        check("short_ready",   s_ready,  0);
        check("short_cnt",     load_cnt, 2);
        step();
        check("short_err_drop", err, 0);
        check("short_coef",     coef_all(), 64'h0100_0200_0300_0400);

        // Long set: four beats without s_last
        start_load();
        beat(16'h000A, 1'b0);
        beat(16'h000B, 1'b0);
        beat(16'h000C, 1'b0);
        check("long_no_err_yet", err, 0);
        beat(16'h000D, 1'b0);
        check("long_err",      err,      1);
        check("long_pending",  pending,  0);
        check("long_coef",     coef_all(), 64'h0100_0200_0300_0400);
        check("long_bank_sel", bank_sel, 1);
        step();
        check("long_err_drop", err, 0);

        // Abort concurrent with beat 2
        start_load();
        beat(16'h5555, 1'b0);
        load_abort = 1'b1;
        beat(16'h6666, 1'b0);
        load_abort = 1'b0;
        check("abort_cnt",   load_cnt, 1);
        check("abort_ready", s_ready,  0);
        check("abort_err",   err,      0);
        // Full load afterwards into bank 0
        start_load();
        beat(16'h0011, 1'b0);
        beat(16'h0022, 1'b0);
        beat(16'h0033, 1'b0);
        beat(16'h0044, 1'b1);
        check("ld2_pending", pending, 1);
        do_swap();
        check("sw2_coef",      coef_all(), 64'h0011_0022_0033_0044);
        check("sw2_bank_sel",  bank_sel,  0);
        check("sw2_swap_done", swap_done, 1);

        // load_start and swap_en together: swap wins
        start_load();
        beat(16'h0AAA, 1'b0);
        beat(16'h0BBB, 1'b0);
        beat(16'h0CCC, 1'b0);
        beat(16'h0DDD, 1'b1);
        load_start = 1'b1;
        swap_en    = 1'b1;
        step();
        load_start = 1'b0;
        swap_en    = 1'b0;
        check("both_coef",      coef_all(), 64'h0AAA_0BBB_0CCC_0DDD);
        check("both_bank_sel",  bank_sel,  1);
        check("both_swap_done", swap_done, 1);
        check("both_ready",     s_ready,   0);
        step();
        check("both_idle_ready", s_ready, 0);

        // load_start in PENDING discards the pending set
        start_load();
        beat(16'h0001, 1'b0);
        beat(16'h0002, 1'b0);
        beat(16'h0003, 1'b0);
        beat(16'h0004, 1'b1);
        check("ldB_pending", pending, 1);
        start_load();
        check("reld_pending", pending,  0);
        check("reld_ready",   s_ready,  1);
        check("reld_cnt",     load_cnt, 0);
        check("reld_coef",    coef_all(), 64'h0AAA_0BBB_0CCC_0DDD);

        // Asynchronous reset mid-load, away from any clock edge
        beat(16'h0E01, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_coef",     coef_all(), 64'h0);
        check("arst_bank_sel", bank_sel, 0);
        check("arst_ready",    s_ready,  0);
        check("arst_cnt",      load_cnt, 0);
        check("arst_pending",  pending,  0);
        #3 rst_n = 1'b1;
        step();
        check("post_rst_ready", s_ready,    0);
        check("post_rst_coef",  coef_all(), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
